adma_as_atx_split: RTL
======================

Name: adma_as_atx_split

Overview:
- Sits directly upstream of the AXI-transaction status tracker in the AXI DMA datapath.
- Accepts one DMA transaction descriptor (start address, beat count) and splits it into AXI bursts (ATXs).
- Each burst respects the AXI maximum burst length and never crosses a 4 KB address boundary.
- Issues the bursts one at a time over a valid/ready interface and emits the per-burst start and last-burst-start strobes that the status tracker consumes.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, AXI data width in bits; bytes per beat BPB = DATA_W/8 (power of 2, 1..128).
- DMA_LENGTH_W, 16, width of the descriptor length field.
- MAX_BURST, 256, maximum beats per ATX (power of 2, 1..256).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tx_vld_i  in  1  descriptor valid
- tx_rdy_o  out  1  descriptor ready
- tx_addr_i  in  ADDR_W  transaction start byte address
- tx_len_i  in  DMA_LENGTH_W  beats minus 1
- atx_vld_o  out  1  burst request valid
- atx_rdy_i  in  1  burst request accepted
- atx_addr_o  out  ADDR_W  burst start address, beat-aligned
- atx_len_o  out  8  AXI LEN (beats minus 1)
- atx_last_o  out  1  this burst is the final burst of the transaction
- atx_start_o  out  1  burst handshake = atx_vld_o & atx_rdy_i
- atx_start_last_o  out  1  atx_start_o & atx_last_o
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - Outputs: tx_rdy_o=1, atx_vld_o=0, atx_addr_o=0, atx_len_o=0, atx_last_o=0, busy_o=0.
  - Internal address and remaining-beat registers cleared.
- FSM states: IDLE, CALC, ISSUE.
- IDLE:
  - tx_rdy_o=1.
  - On tx_vld_i, capture the address with its low log2(BPB) bits forced to 0.
  - Capture remaining = tx_len_i + 1, held in DMA_LENGTH_W+1 bits so no overflow.
  - Go to CALC.
- CALC (one cycle, tx_rdy_o=0, atx_vld_o=0):
  - bnd = (4096 - addr[11:0]) >> log2(BPB), evaluated in 13 bits.
  - beats = min(remaining, MAX_BURST, bnd).
  - Register outputs: atx_addr_o = addr, atx_len_o = beats-1, atx_last_o = (beats == remaining).
  - Go to ISSUE.
- ISSUE:
  - atx_vld_o=1. Address, length and last are held stable until atx_rdy_i.
  - On handshake: addr += beats*BPB (modulo 2^ADDR_W), remaining -= beats.
  - If atx_last_o was set, go to IDLE; otherwise go to CALC.
- atx_start_o and atx_start_last_o are purely combinational from the handshake, so they pulse exactly 1 cycle per burst. atx_start_last_o pulses exactly once per transaction.
- Latency and throughput:
  - The first atx_vld_o rises 2 cycles after the descriptor handshake.
  - Consecutive bursts are at least 2 cycles apart.
  - tx_rdy_o returns high the cycle after the last handshake, so the next descriptor can be accepted then.
- Every descriptor yields at least one burst (minimum 1 beat).
- A new descriptor is never accepted while busy_o=1.
- Address wrap at 2^ADDR_W is modulo. It is not an error and produces no special burst.
- No burst ever spans addr[ADDR_W-1:12] changing.
- Reset asserted mid-transaction:
  - Immediately drop atx_vld_o and abandon the remaining beats. No partial last strobe is generated.
  - The downstream status tracker is reset by the same rst_n.

Test Plan:
- Single burst (BPB=4): addr 0x0000_0100, len 15 -> one ATX: addr 0x100, atx_len_o 15, atx_last_o=1; one atx_start_last_o pulse; tx_rdy_o high again 1 cycle after the handshake.
- 4 KB crossing: addr 0x0000_0FF0, len 7 -> ATX0 addr 0xFF0 len 3 last=0; ATX1 addr 0x1000 len 3 last=1.
- Long transaction: addr 0x0000_1000, len 599 -> ATXs (0x1000, 255), (0x1400, 255), (0x1800, 87 last); exactly 3 atx_start_o and 1 atx_start_last_o pulses.
- Backpressure: atx_rdy_i held low 10 cycles during ISSUE -> atx_vld_o stays 1 with addr/len/last unchanged; no atx_start_o pulse until atx_rdy_i rises.
- Misaligned address and wrap: addr 0xFFFF_FFF3, len 3 -> ATX0 addr 0xFFFF_FFF0 len 3 last=1. Then a second descriptor at addr 0xFFFF_FFF8, len 3 -> ATX0 (0xFFFF_FFF8, 1), ATX1 (0x0000_0000, 1 last).
- Reset mid-operation: assert rst_n low during ISSUE of ATX1 of a 3-burst transaction -> all outputs return to reset values asynchronously. After release, a new descriptor addr 0x2000, len 0 produces a single ATX (0x2000, 0, last=1).

Source files
------------

// File: rtl/adma_as_atx_split.sv
// rtl/adma_as_atx_split.sv - splits one DMA descriptor into AXI bursts
// Bursts are capped at MAX_BURST beats and never cross a 4 KB boundary.
module adma_as_atx_split #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int DMA_LENGTH_W = 16,
  parameter int MAX_BURST    = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tx_vld_i,
  output logic                    tx_rdy_o,
  input  logic [ADDR_W-1:0]       tx_addr_i,
  input  logic [DMA_LENGTH_W-1:0] tx_len_i,
  output logic                    atx_vld_o,
  input  logic                    atx_rdy_i,
  output logic [ADDR_W-1:0]       atx_addr_o,
  output logic [7:0]              atx_len_o,
  output logic                    atx_last_o,
  output logic                    atx_start_o,
  output logic                    atx_start_last_o,
  output logic                    busy_o
);
  localparam int BPB   = DATA_W / 8;
  localparam int OFF_W = $clog2(BPB);
  localparam int REM_W = DMA_LENGTH_W + 1;
  localparam int CW    = (REM_W > 13) ? REM_W : 13;

  typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [REM_W-1:0]  r_rem;
  logic [8:0]        r_beats;
  logic              r_tx_rdy;
  logic              r_atx_vld;
  logic [ADDR_W-1:0] r_atx_addr;
  logic [7:0]        r_atx_len;
  logic              r_atx_last;

  logic [ADDR_W-1:0] w_addr_mask;
  logic [12:0]       w_bnd;
  logic [CW-1:0]     w_rem_ext;
  logic [CW-1:0]     w_bnd_ext;
  logic [CW-1:0]     w_beats_ext;
  logic              w_hs;

  assign w_addr_mask = ~ADDR_W'(BPB - 1);
  // Beats left before the next 4 KB page; 4096 itself needs the 13th bit.
  assign w_bnd       = (13'd4096 - {1'b0, r_addr[11:0]}) >> OFF_W;
  assign w_rem_ext   = CW'(r_rem);
  assign w_bnd_ext   = CW'(w_bnd);

  always_comb begin
    w_beats_ext = CW'(MAX_BURST);
    if (w_rem_ext < w_beats_ext) w_beats_ext = w_rem_ext;
    if (w_bnd_ext < w_beats_ext) w_beats_ext = w_bnd_ext;
  end

  assign w_hs = r_atx_vld & atx_rdy_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_beats    <= '0;
      r_tx_rdy   <= 1'b1;
      r_atx_vld  <= 1'b0;
      r_atx_addr <= '0;
      r_atx_len  <= '0;
      r_atx_last <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (tx_vld_i) begin
            r_addr   <= tx_addr_i & w_addr_mask;
            r_rem    <= REM_W'(tx_len_i) + REM_W'(1);
            r_tx_rdy <= 1'b0;
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_beats    <= 9'(w_beats_ext);
          r_atx_addr <= r_addr;
          r_atx_len  <= 8'(w_beats_ext - CW'(1));
          r_atx_last <= (w_beats_ext == w_rem_ext);
          r_atx_vld  <= 1'b1;
          r_state    <= ISSUE;
        end
        ISSUE: begin
          if (w_hs) begin
            r_addr    <= r_addr + (ADDR_W'(r_beats) << OFF_W);
            r_rem     <= r_rem - REM_W'(r_beats);
            r_atx_vld <= 1'b0;
            if (r_atx_last) begin
              r_tx_rdy <= 1'b1;
              r_state  <= IDLE;
            end else begin
              r_state  <= CALC;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_tx_rdy  <= 1'b1;
          r_atx_vld <= 1'b0;
        end
      endcase
    end
  end

  assign tx_rdy_o         = r_tx_rdy;
  assign atx_vld_o        = r_atx_vld;
  assign atx_addr_o       = r_atx_addr;
  assign atx_len_o        = r_atx_len;
  assign atx_last_o       = r_atx_last;
  assign atx_start_o      = w_hs;
  assign atx_start_last_o = w_hs & r_atx_last;
  assign busy_o           = (r_state != IDLE);
endmodule
